// File: rtl/msk_rnd_pkg.sv
// Shared constants, FSM encoding and single-step LFSR function for the
// masked-gadget randomness source.
package msk_rnd_pkg;

  localparam int unsigned LFSR_W     = 128;
  localparam int unsigned SEED_WORDS = 4;
  localparam int unsigned SEED_W     = 32;

  // Feedback taps of x^128 + x^126 + x^101 + x^99 + 1
  localparam int unsigned TAP_A = 127;
  localparam int unsigned TAP_B = 125;
  localparam int unsigned TAP_C = 100;
  localparam int unsigned TAP_D = 98;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } fsm_e;

  function automatic logic [LFSR_W-1:0] lfsr_step1(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

endpackage

// File: rtl/msk_rnd_prng_if.sv
// Seed port and random-beat port of the PRNG; slave is the PRNG side.
interface msk_rnd_prng_if #(
  parameter int unsigned RND_W = 2
);

  logic [31:0]      seed_in;
  logic             seed_valid;
  logic             seed_ready;
  logic             reseed;
  logic [RND_W-1:0] rnd_out;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (
    output seed_in, seed_valid, reseed, rnd_ready,
    input  seed_ready, rnd_out, rnd_valid
  );

  modport slave (
    input  seed_in, seed_valid, reseed, rnd_ready,
    output seed_ready, rnd_out, rnd_valid
  );

endinterface

// File: rtl/msk_lfsr_step.sv
// Purely combinational N-step advance of the 128-bit Fibonacci LFSR.
module msk_lfsr_step
  import msk_rnd_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt_c
);

  always_comb begin
    nxt_c = cur;
    for (int i = 0; i < int'(N); i++) begin
      nxt_c = lfsr_step1(nxt_c);
    end
  end

endmodule

// File: rtl/msk_rnd_prng.sv
// Fresh-randomness producer for masked gadgets: seeded 128-bit LFSR that
// streams RND_W bits per accepted beat after a warm-up phase.
module msk_rnd_prng
  import msk_rnd_pkg::*;
#(
  parameter int unsigned d          = 2,
  parameter int unsigned RND_W      = d * (d - 1),
  parameter int unsigned WARMUP_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  msk_rnd_prng_if.slave  bus
);

  localparam int unsigned WARM_CW   = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int unsigned WARM_LAST = (WARMUP_CYC == 0) ? 0 : WARMUP_CYC - 1;
  localparam logic [WARM_CW-1:0] WARM_LAST_V = WARM_CW'(WARM_LAST);
  localparam logic [1:0]         LAST_WORD   = 2'(SEED_WORDS - 1);
  localparam bit                 SKIP_WARM   = (WARMUP_CYC == 0);

  fsm_e               fsm, fsm_nxt;
  logic [LFSR_W-1:0]  state, state_nxt;
  logic [1:0]         word_cnt, word_cnt_nxt;
  logic [WARM_CW-1:0] warm_cnt, warm_cnt_nxt;
  logic [RND_W-1:0]   rnd_q, rnd_nxt;
  logic               seed_ready_q;
  logic               rnd_valid_q;

  logic [LFSR_W-1:0]  stepped_c;
  logic [LFSR_W-1:0]  asm_c;

  msk_lfsr_step #(.N(RND_W)) u_step (
    .cur   (state),
    .nxt_c (stepped_c)
  );

  // Current state with the incoming seed word dropped into its slot
  always_comb begin
    asm_c = state;
    asm_c[SEED_W * word_cnt +: SEED_W] = bus.seed_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= LOAD;
      state        <= '0;
      word_cnt     <= '0;
      warm_cnt     <= '0;
      rnd_q        <= '0;
      seed_ready_q <= 1'b1;
      rnd_valid_q  <= 1'b0;
    end else begin
      fsm          <= fsm_nxt;
      state        <= state_nxt;
      word_cnt     <= word_cnt_nxt;
      warm_cnt     <= warm_cnt_nxt;
      rnd_q        <= rnd_nxt;
      seed_ready_q <= (fsm_nxt == LOAD);
      rnd_valid_q  <= (fsm_nxt == RUN);
    end
  end

  always_comb begin
    fsm_nxt      = fsm;
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    warm_cnt_nxt = warm_cnt;
    rnd_nxt      = rnd_q;

    unique case (fsm)
      LOAD: begin
        if (bus.seed_valid) begin
          state_nxt    = asm_c;
          word_cnt_nxt = word_cnt + 2'd1;
          if (word_cnt == LAST_WORD) begin
            // An all-zero LFSR never leaves zero
            if (asm_c == '0) begin
              state_nxt = LFSR_W'(1);
            end
            warm_cnt_nxt = '0;
            fsm_nxt      = SKIP_WARM ? RUN : WARMUP;
          end
        end
      end
      WARMUP: begin
        state_nxt    = stepped_c;
        rnd_nxt      = stepped_c[RND_W-1:0];
        warm_cnt_nxt = warm_cnt + WARM_CW'(1);
        if (warm_cnt == WARM_LAST_V) begin
          warm_cnt_nxt = '0;
          fsm_nxt      = RUN;
        end
      end
      RUN: begin
        if (bus.rnd_ready) begin
          state_nxt = stepped_c;
          rnd_nxt   = stepped_c[RND_W-1:0];
        end
      end
      default: begin
        fsm_nxt = LOAD;
      end
    endcase

    // Reseed wins over any same-cycle seed or beat handshake
    if (bus.reseed) begin
      fsm_nxt      = LOAD;
      state_nxt    = '0;
      word_cnt_nxt = '0;
      warm_cnt_nxt = '0;
      rnd_nxt      = '0;
    end
  end

  assign bus.seed_ready = seed_ready_q;
  assign bus.rnd_valid  = rnd_valid_q;
  assign bus.rnd_out    = rnd_q;

endmodule
